alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have parameter: N, 8, operand and result width in bits (N >= 2, power of two).
REQ-002 SHALL have one clock and reset; reset is asynchronous and active-high.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port: in_valid  input  1  operands/opcode valid this cycle.
REQ-006 SHALL have port: A  input  N  operand A, unsigned/two's complement.
REQ-007 SHALL have port: B  input  N  operand B, unsigned/two's complement.
REQ-008 SHALL have port: opcode  input  3  operation select.
REQ-009 SHALL have port: out_valid  output  1  Y/flags hold a new result.
REQ-010 SHALL have port: Y  output  N  registered result.
REQ-011 SHALL have ports: carry, overflow, zero, negative  output  1 each  registered status flags.

Function
REQ-012 SHALL decode opcode: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOT A; 6 SHL A<<B[log2(N)-1:0]; 7 SHR (logical) A>>B[log2(N)-1:0].
REQ-013 SHALL truncate all results to N bits (modulo 2^N wrap-around).
REQ-014 SHALL register the result: when in_valid=1 at a rising clk edge, Y and flags update at that edge; latency 1 cycle.
REQ-015 SHALL set out_valid=in_valid registered each cycle; back-to-back operations supported, one result per cycle, no stall.
REQ-016 SHALL hold Y and flags unchanged when in_valid=0; out_valid drops to 0 in the following cycle.
REQ-017 SHALL shift by B modulo N only (upper B bits ignored); shift-in bits are 0.
REQ-018 carry: ADD = bit N carry-out; SUB = 1 when A < B unsigned (borrow); all other ops = 0.
REQ-019 overflow: ADD = operands same sign, result sign differs; SUB = operands differ in sign, result sign differs from A; others = 0.
REQ-020 zero = 1 when the N-bit result is all zeros; negative = result bit N-1; both for every opcode.
REQ-021 SHALL be purely combinational from inputs to the D side of the output registers; no X propagation for any opcode value.

Reset
REQ-022 SHALL on rst=1 immediately (asynchronously) clear Y, carry, overflow, negative, out_valid to 0 and set zero to 0.
REQ-023 SHALL ignore in_valid while rst=1; the first result after rst deasserts appears one edge after the first in_valid=1.
REQ-024 SHALL discard an operation in flight when reset asserts mid-operation; no result is produced for it.

Configuration
REQ-025 SHALL support macro ALU_FLAGS_EN: defined -> carry, overflow, zero, negative computed per REQ-018..020; undefined -> flag registers omitted and all four flag outputs tied to 0; Y and out_valid unaffected.

Verification
REQ-026 N=8, A=73, B=42, in_valid=1, opcodes 0..7 on consecutive cycles -> Y one cycle later = 115, 31, 8, 107, 99, 182, 36, 18; out_valid=1 for each.
REQ-027 ADD A=200, B=100 -> Y=44, carry=1, overflow=0; ADD A=100, B=50 -> Y=150, overflow=1, negative=1, carry=0.
REQ-028 SUB A=5, B=5 -> Y=0, zero=1, carry=0; SUB A=3, B=5 -> Y=254, carry=1, negative=1.
REQ-029 SHL A=1, B=15 (shift 7) -> Y=128; SHR A=128, B=8 (shift 0) -> Y=128.
REQ-030 Assert rst between clock edges with out_valid=1, Y=115 -> Y=0, out_valid=0 immediately; hold in_valid=0 after release -> outputs stay 0.
REQ-031 Compile without ALU_FLAGS_EN, ADD A=200, B=100 -> Y=44, all flags 0.

Source files
------------

// File: rtl/alu.sv
// Registered N-bit ALU: eight operations, one result per cycle, latency 1.
// Ports: clk, rst (async, active-high); in_valid, A, B, opcode in;
//        out_valid, Y, carry, overflow, zero, negative out.
// Optional flags: define ALU_FLAGS_EN to compute carry/overflow/zero/negative;
//        otherwise the flag registers are omitted and the flags read 0.

module alu #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   opcode,
    output logic         out_valid,
    output logic [N-1:0] Y,
    output logic         carry,
    output logic         overflow,
    output logic         zero,
    output logic         negative
);

    localparam int SW = $clog2(N);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    // Shift distance is B modulo N; upper B bits never reach the shifter.
    logic [SW-1:0] sh;
    logic [N-1:0]  y_d;

    assign sh = B[SW-1:0];

    always_comb begin
        y_d = '0;
        unique case (opcode)
            OP_ADD: y_d = A + B;
            OP_SUB: y_d = A - B;
            OP_AND: y_d = A & B;
            OP_OR:  y_d = A | B;
            OP_XOR: y_d = A ^ B;
            OP_NOT: y_d = ~A;
            OP_SHL: y_d = A << sh;
            OP_SHR: y_d = A >> sh;
            default: y_d = '0;
        endcase
    end

    // Result and valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y <= '0;
        end else if (in_valid) begin
            Y <= y_d;
        end
    end

`ifdef ALU_FLAGS_EN

    // Extra MSB on the add/sub paths holds carry-out / borrow.
    logic [N:0] sum_w;
    logic [N:0] dif_w;
    logic       c_d;
    logic       v_d;
    logic       z_d;
    logic       n_d;
    logic       sa;
    logic       sb;

    assign sum_w = {1'b0, A} + {1'b0, B};
    assign dif_w = {1'b0, A} - {1'b0, B};
    assign sa    = A[N-1];
    assign sb    = B[N-1];

    always_comb begin
        c_d = 1'b0;
        v_d = 1'b0;
        unique case (opcode)
            OP_ADD: begin
                c_d = sum_w[N];
                v_d = (sa == sb) && (sum_w[N-1] != sa);
            end
            OP_SUB: begin
                // Borrow out of the wide subtract means A < B unsigned.
                c_d = dif_w[N];
                v_d = (sa != sb) && (dif_w[N-1] != sa);
            end
            default: begin
                c_d = 1'b0;
                v_d = 1'b0;
            end
        endcase
        z_d = (y_d == '0);
        n_d = y_d[N-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else if (in_valid) begin
            carry    <= c_d;
            overflow <= v_d;
            zero     <= z_d;
            negative <= n_d;
        end
    end

`else

    assign carry    = 1'b0;
    assign overflow = 1'b0;
    assign zero     = 1'b0;
    assign negative = 1'b0;

`endif

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu (N=8): table of ops/results plus
// hand-written reset and hold sequences.

module tb_alu;

    localparam int N = 8;

`ifdef ALU_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   opcode;
    logic         out_valid;
    logic [N-1:0] Y;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         negative;

    int checks   = 0;
    int failures = 0;

    alu #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .out_valid (out_valid),
        .Y         (Y),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] y;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic ov,
                           input logic [N-1:0] y, input logic c,
                           input logic v, input logic z, input logic n);
        chk({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        chk({name, ".Y"}, {24'd0, Y}, {24'd0, y});
        chk({name, ".carry"}, {31'd0, carry}, {31'd0, c & FL});
        chk({name, ".overflow"}, {31'd0, overflow}, {31'd0, v & FL});
        chk({name, ".zero"}, {31'd0, zero}, {31'd0, z & FL});
        chk({name, ".negative"}, {31'd0, negative}, {31'd0, n & FL});
    endtask

    vec_t vt[17];

    initial begin
        //         op    a     b     y     c v z n
        vt[0]  = '{3'd0, 8'd73, 8'd42, 8'd115, 0, 0, 0, 0};
        vt[1]  = '{3'd1, 8'd73, 8'd42, 8'd31,  0, 0, 0, 0};
        vt[2]  = '{3'd2, 8'd73, 8'd42, 8'd8,   0, 0, 0, 0};
        vt[3]  = '{3'd3, 8'd73, 8'd42, 8'd107, 0, 0, 0, 0};
        vt[4]  = '{3'd4, 8'd73, 8'd42, 8'd99,  0, 0, 0, 0};
        vt[5]  = '{3'd5, 8'd73, 8'd42, 8'd182, 0, 0, 0, 1};
        vt[6]  = '{3'd6, 8'd73, 8'd42, 8'd36,  0, 0, 0, 0};
        vt[7]  = '{3'd7, 8'd73, 8'd42, 8'd18,  0, 0, 0, 0};
        vt[8]  = '{3'd0, 8'd200, 8'd100, 8'd44, 1, 0, 0, 0};
        vt[9]  = '{3'd0, 8'd100, 8'd50, 8'd150, 0, 1, 0, 1};
        vt[10] = '{3'd1, 8'd5,   8'd5,  8'd0,   0, 0, 1, 0};
        vt[11] = '{3'd1, 8'd3,   8'd5,  8'd254, 1, 0, 0, 1};
        vt[12] = '{3'd6, 8'd1,   8'd15, 8'd128, 0, 0, 0, 1};
        vt[13] = '{3'd7, 8'd128, 8'd8,  8'd128, 0, 0, 0, 1};
        // SUB overflow: -128 - 1 wraps to +127.
        vt[14] = '{3'd1, 8'd128, 8'd1,  8'd127, 0, 1, 0, 0};
        vt[15] = '{3'd0, 8'd255, 8'd1,  8'd0,   1, 0, 1, 0};
        vt[16] = '{3'd7, 8'd255, 8'd255, 8'd1,  0, 0, 0, 0};

        rst = 1'b1;
        in_valid = 1'b0;
        A = '0;
        B = '0;
        opcode = '0;
        #2;
        chk_out("reset", 1'b0, 8'd0, 0, 0, 0, 0);

        // in_valid ignored while reset is held.
        in_valid = 1'b1;
        A = 8'd9;
        B = 8'd9;
        @(posedge clk);
        #1;
        chk_out("rst_ignore", 1'b0, 8'd0, 0, 0, 0, 0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_out("post_rst_idle", 1'b0, 8'd0, 0, 0, 0, 0);

        // Back-to-back table: one new vector each cycle.
        for (int i = 0; i < 17; i++) begin
            opcode = vt[i].op;
            A = vt[i].a;
            B = vt[i].b;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", i), 1'b1, vt[i].y,
                    vt[i].c, vt[i].v, vt[i].z, vt[i].n);
        end

        // Hold: in_valid low keeps Y/flags, drops out_valid.
        in_valid = 1'b0;
        opcode = 3'd0;
        A = 8'd1;
        B = 8'd1;
        @(posedge clk);
        #1;
        chk_out("hold1", 1'b0, 8'd1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_out("hold2", 1'b0, 8'd1, 0, 0, 0, 0);

        // Produce Y=115, then assert reset mid-cycle.
        opcode = 3'd0;
        A = 8'd73;
        B = 8'd42;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_out("pre_rst", 1'b1, 8'd115, 0, 0, 0, 0);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 8'd0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk_out($sformatf("rst_idle%0d", k), 1'b0, 8'd0, 0, 0, 0, 0);
        end

        // In-flight op discarded when reset lands before its edge.
        opcode = 3'd0;
        A = 8'd200;
        B = 8'd100;
        in_valid = 1'b1;
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_out("inflight", 1'b0, 8'd0, 0, 0, 0, 0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_out("inflight_after", 1'b0, 8'd0, 0, 0, 0, 0);

        // First result after reset arrives one edge after in_valid.
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_out("first_after_rst", 1'b1, 8'd44, 1, 0, 0, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
